// File: rtl/tcb_lib_memory.sv
// TCB subordinate byte-addressable RAM: zero-fills itself after reset, then serves
// one request per cycle with a fixed DLY-cycle response and range-error reporting.
module tcb_lib_memory #(
    parameter int unsigned ADR = 32,
    parameter int unsigned DAT = 32,
    parameter int unsigned SIZ = 4096,
    parameter int unsigned DLY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tcb_vld,
    output logic               tcb_rdy,
    input  logic               tcb_wen,
    input  logic [ADR-1:0]     tcb_adr,
    input  logic [DAT/8-1:0]   tcb_ben,
    input  logic [DAT-1:0]     tcb_wdt,
    output logic [DAT-1:0]     tcb_rdt,
    output logic               tcb_err
);

    localparam int unsigned BYT = DAT / 8;
    localparam int unsigned WRD = SIZ / BYT;
    localparam int unsigned SAW = $clog2(SIZ);
    localparam int unsigned OFF = $clog2(BYT);
    localparam int unsigned IW  = (SAW > OFF) ? SAW - OFF : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   cnt, cnt_nxt;

    logic            trn;
    logic            oor;
    logic [IW-1:0]   idx;

    logic            mem_we;
    logic [IW-1:0]   mem_adr;
    logic [BYT-1:0]  mem_ben;
    logic [DAT-1:0]  mem_wdt;
    logic            rd_en;

    logic [DAT-1:0]  mem [WRD];
    logic [DAT-1:0]  rd_q;
    logic            s1_sel;
    logic            s1_err;
    logic [DAT-1:0]  s1_rdt;

    assign trn = tcb_vld & tcb_rdy;
    assign oor = |(tcb_adr >> SAW);

    generate
        if (SAW > OFF) begin : g_idx
            assign idx = tcb_adr[SAW-1:OFF];
        end else begin : g_idx1
            assign idx = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tcb_rdy   = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = idx;
        mem_ben   = tcb_ben;
        mem_wdt   = tcb_wdt;
        case (state)
            INIT: begin
                mem_we  = 1'b1;
                mem_adr = cnt;
                mem_ben = '1;
                mem_wdt = '0;
                cnt_nxt = cnt + 1'b1;
                if (cnt == IW'(WRD - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                tcb_rdy = 1'b1;
                mem_we  = trn & tcb_wen & ~oor;
            end
            default: state_nxt = INIT;
        endcase
    end

    assign rd_en = trn & ~tcb_wen & ~oor;

    // RAM kept free of reset so it maps onto a block RAM; rd_q is masked by s1_sel instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < BYT; i++) begin
                if (mem_ben[i]) mem[mem_adr][8*i +: 8] <= mem_wdt[8*i +: 8];
            end
        end
        if (rd_en) rd_q <= mem[mem_adr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sel <= 1'b0;
            s1_err <= 1'b0;
        end else if (trn) begin
            s1_sel <= ~tcb_wen & ~oor;
            s1_err <= oor;
        end
    end

    assign s1_rdt = s1_sel ? rd_q : '0;

    generate
        if (DLY == 1) begin : g_d1
            assign tcb_rdt = s1_rdt;
            assign tcb_err = s1_err;
        end else begin : g_dn
            logic [DAT-1:0] p_rdt [2:DLY];
            logic           p_err [2:DLY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 2; i <= DLY; i++) begin
                        p_rdt[i] <= '0;
                        p_err[i] <= 1'b0;
                    end
                end else begin
                    p_rdt[2] <= s1_rdt;
                    p_err[2] <= s1_err;
                    for (int unsigned i = 3; i <= DLY; i++) begin
                        p_rdt[i] <= p_rdt[i-1];
                        p_err[i] <= p_err[i-1];
                    end
                end
            end

            assign tcb_rdt = p_rdt[DLY];
            assign tcb_err = p_err[DLY];
        end
    endgenerate

endmodule

// File: tb/tb_tcb_lib_memory.sv
// Directed bench for tcb_lib_memory: two instances (DLY=1 and DLY=3) share one request stream.
module tb_tcb_lib_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] adr = '0;
    logic [3:0]  ben = '0;
    logic [31:0] wdt = '0;

    logic        rdy1, err1, rdy3, err3;
    logic [31:0] rdt1, rdt3;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    tcb_lib_memory #(.ADR(32), .DAT(32), .SIZ(4096), .DLY(1)) u1 (
        .clk(clk), .rst(rst), .tcb_vld(vld), .tcb_rdy(rdy1), .tcb_wen(wen),
        .tcb_adr(adr), .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt1), .tcb_err(err1)
    );

    tcb_lib_memory #(.ADR(32), .DAT(32), .SIZ(4096), .DLY(3)) u3 (
        .clk(clk), .rst(rst), .tcb_vld(vld), .tcb_rdy(rdy3), .tcb_wen(wen),
        .tcb_adr(adr), .tcb_ben(ben), .tcb_wdt(wdt), .tcb_rdt(rdt3), .tcb_err(err3)
    );

    typedef struct {
        logic        w;
        logic [31:0] adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
        logic [31:0] rdt;
        logic        err;
        string       name;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [3:0] b,
                                input logic [31:0] d, input logic [31:0] r, input logic e,
                                input string n);
        vec_t v;
        v.w = w; v.adr = a; v.ben = b; v.wdt = d; v.rdt = r; v.err = e; v.name = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One isolated transfer; checks DLY=1 output after 1 cycle and DLY=3 output after 3.
    task automatic xfer(input vec_t v);
        @(negedge clk);
        vld = 1'b1; wen = v.w; adr = v.adr; ben = v.ben; wdt = v.wdt;
        @(negedge clk);
        vld = 1'b0;
        chk({v.name, "_rdt1"}, rdt1, v.rdt);
        chk({v.name, "_err1"}, 32'(err1), 32'(v.err));
        @(negedge clk);
        @(negedge clk);
        chk({v.name, "_rdt3"}, rdt3, v.rdt);
        chk({v.name, "_err3"}, 32'(err3), 32'(v.err));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        vld = 1'b1; wen = 1'b1; adr = a; ben = 4'hF; wdt = d;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic count_init(input string name);
        int unsigned n = 0;
        while (!rdy1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, n, 32'd1024);
        chk({name, "_rdy3"}, 32'(rdy3), 32'd1);
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0000_0000, 1'b0, "rd_zero");
        vecs[1]  = mk(1'b1, 32'h0000_0010, 4'h5, 32'hDEADBEEF,  32'h0000_0000, 1'b0, "wr_ben5");
        vecs[2]  = mk(1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h00AD00EF, 1'b0, "rd_ben5");
        vecs[3]  = mk(1'b1, 32'h0000_0013, 4'hF, 32'h11223344,  32'h0000_0000, 1'b0, "wr_mis");
        vecs[4]  = mk(1'b0, 32'h0000_0010, 4'h3, 32'h0,         32'h11223344, 1'b0, "rd_mis");
        vecs[5]  = mk(1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'h0000_0000, 1'b1, "rd_oor");
        vecs[6]  = mk(1'b1, 32'h0000_1000, 4'hF, 32'hFFFFFFFF,  32'h0000_0000, 1'b1, "wr_oor");
        vecs[7]  = mk(1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0000_0000, 1'b0, "rd_w0");
        vecs[8]  = mk(1'b1, 32'h0000_0004, 4'h0, 32'hAAAAAAAA,  32'h0000_0000, 1'b0, "wr_ben0");
        vecs[9]  = mk(1'b0, 32'h0000_0004, 4'h0, 32'h0,         32'h0000_0000, 1'b0, "rd_ben0");
        vecs[10] = mk(1'b1, 32'h0000_0004, 4'hA, 32'hA5B6C7D8,  32'h0000_0000, 1'b0, "wr_benA");
        vecs[11] = mk(1'b0, 32'h0000_0006, 4'h0, 32'h0,         32'hA500C700, 1'b0, "rd_benA");
        vecs[12] = mk(1'b0, 32'h8000_0000, 4'h0, 32'h0,         32'h0000_0000, 1'b1, "rd_hi");

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdy1", 32'(rdy1), 32'd0);
        chk("rst_rdt1", rdt1, 32'd0);
        chk("rst_err3", 32'(err3), 32'd0);
        chk("rst_rdt3", rdt3, 32'd0);
        rst = 1'b0;
        count_init("init_len");

        foreach (vecs[i]) xfer(vecs[i]);

        // Last word of the array, read back through a misaligned address
        wr(32'h0000_0FFC, 32'h12345678);
        xfer(mk(1'b0, 32'h0000_0FFF, 4'h0, 32'h0, 32'h12345678, 1'b0, "rd_last"));

        // Write immediately followed by read of the same word
        @(negedge clk);
        vld = 1'b1; wen = 1'b1; adr = 32'h20; ben = 4'hF; wdt = 32'hCAFEF00D;
        @(negedge clk);
        wen = 1'b0;
        @(negedge clk);
        vld = 1'b0;
        chk("wr_rd_b2b", rdt1, 32'hCAFEF00D);

        // Back-to-back reads of words preloaded with i+1
        for (int i = 0; i < 8; i++) wr(32'(4 * i), 32'(i + 1));
        for (int j = 0; j <= 10; j++) begin
            @(negedge clk);
            if (j >= 1 && j <= 8) chk($sformatf("b2b_d1_%0d", j - 1), rdt1, 32'(j));
            if (j >= 3) chk($sformatf("b2b_d3_%0d", j - 3), rdt3, 32'(j - 2));
            if (j < 8) begin
                vld = 1'b1; wen = 1'b0; adr = 32'(4 * j);
            end else begin
                vld = 1'b0;
            end
        end

        // Reset in RUN with nonzero outputs, then again mid-init
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_run_rdt1", rdt1, 32'd0);
        chk("rst_run_rdt3", rdt3, 32'd0);
        chk("rst_run_rdy", 32'(rdy1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (500) @(negedge clk);
        chk("mid_init_rdy", 32'(rdy1), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", 32'(rdy1), 32'd0);
        chk("mid_rst_err1", 32'(err1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_init("reinit_len");
        xfer(mk(1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h0000_0000, 1'b0, "rd_cleared"));
        xfer(mk(1'b0, 32'h0000_001C, 4'h0, 32'h0, 32'h0000_0000, 1'b0, "rd_cleared7"));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
